// File: rtl/arb_pkg.sv
// Shared types and sizes for the round-robin grant encoder that feeds the 4-to-16 decoder.
package arb_pkg;
   localparam int N     = 16;
   localparam int IDX_W = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   typedef logic [IDX_W-1:0] idx_t;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping modulo N.
module rr_pick
   import arb_pkg::*;
(
   input  logic [N-1:0] req,
   input  idx_t         ptr,
   output idx_t         idx,
   output logic         any
);

   logic [2*N-1:0] doubled;
   logic [N-1:0]   window;
   idx_t           offset;

   // The doubled vector turns the circular scan into a plain priority encode from bit 0.
   always_comb begin
      doubled = {req, req};
      window  = doubled[ptr +: N];
      offset  = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (window[i]) offset = idx_t'(i);
      end
      any = |req;
      idx = ptr + offset;
   end

endmodule

// File: rtl/rr_grant_encoder.sv
// Round-robin arbiter driving a registered owner index and valid strobe into the 4-to-16 decoder.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | no owner; grant_valid low; picks next owner from ptr
//   GRANT | owner held in grant_idx until rel, request drop or timeout
module rr_grant_encoder #(
   parameter int N       = arb_pkg::N,
   parameter int IDX_W   = arb_pkg::IDX_W,
   parameter int TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     req,
   input  logic             rel,
   output logic [IDX_W-1:0] grant_idx,
   output logic             grant_valid,
   output logic             timeout_o
);
   import arb_pkg::*;

   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   typedef logic [CNT_W-1:0] cnt_t;
   localparam cnt_t CNT_LAST = cnt_t'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam cnt_t CNT_MAX  = '1;

   arb_state_e state, state_nxt;
   idx_t       ptr, ptr_nxt;
   cnt_t       cnt, cnt_nxt;
   idx_t       grant_idx_nxt;
   logic       grant_valid_nxt;
   logic       timeout_nxt;

   idx_t       pick_idx;
   logic       pick_any;
   logic       owner_req;
   logic       to_hit;
   logic       release_hit;

   rr_pick u_pick (
      .req (req),
      .ptr (ptr),
      .idx (pick_idx),
      .any (pick_any)
   );

   assign owner_req   = req[grant_idx];
   assign to_hit      = (TIMEOUT != 0) && (cnt == CNT_LAST);
   assign release_hit = rel || !owner_req || to_hit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         ptr         <= '0;
         cnt         <= '0;
         grant_idx   <= '0;
         grant_valid <= 1'b0;
         timeout_o   <= 1'b0;
      end else begin
         state       <= state_nxt;
         ptr         <= ptr_nxt;
         cnt         <= cnt_nxt;
         grant_idx   <= grant_idx_nxt;
         grant_valid <= grant_valid_nxt;
         timeout_o   <= timeout_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (pick_any)    state_nxt = GRANT;
         GRANT:   if (release_hit) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ptr_nxt         = ptr;
      cnt_nxt         = cnt;
      grant_idx_nxt   = grant_idx;
      grant_valid_nxt = grant_valid;
      timeout_nxt     = 1'b0;
      case (state)
         IDLE: begin
            if (pick_any) begin
               grant_idx_nxt   = pick_idx;
               grant_valid_nxt = 1'b1;
               cnt_nxt         = '0;
            end
         end
         GRANT: begin
            if (release_hit) begin
               grant_valid_nxt = 1'b0;
               ptr_nxt         = grant_idx + 1'b1;
               // Flag a timeout only when the owner would otherwise have kept the grant.
               timeout_nxt     = to_hit && !rel && owner_req;
            end else if (cnt != CNT_MAX) begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: begin
            grant_valid_nxt = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_rr_grant_encoder.sv
// Scoreboard bench for rr_grant_encoder with TIMEOUT=8 and a modelled downstream 4-to-16 decoder.
module tb_rr_grant_encoder;
   localparam int TO = 8;

   typedef struct {
      logic [3:0] idx;
      int         len;
      int         gap;
      logic       to;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [15:0] req = '0;
   logic        rel = 1'b0;
   logic [3:0]  grant_idx;
   logic        grant_valid;
   logic        timeout_o;
   logic [15:0] dec;

   int checks = 0;
   int errors = 0;
   exp_t q[$];

   rr_grant_encoder #(.N(16), .IDX_W(4), .TIMEOUT(TO)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .rel         (rel),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid),
      .timeout_o   (timeout_o)
   );

   always #5 clk = ~clk;

   assign dec = grant_valid ? (16'h1 << grant_idx) : 16'h0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
      end
   endtask

   task automatic expect_grant(input logic [3:0] idx, input int len, input int gap, input logic to);
      exp_t e;
      e.idx = idx;
      e.len = len;
      e.gap = gap;
      e.to  = to;
      q.push_back(e);
   endtask

   task automatic wait_grant();
      bit seen = 0;
      for (int i = 0; i < 64; i++) begin
         if (grant_valid) begin
            seen = 1;
            break;
         end
         @(posedge clk);
         #1;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL wait_grant: got no grant expected grant within 64 cycles");
      end
   endtask

   task automatic wait_drop();
      bit seen = 0;
      for (int i = 0; i < 64; i++) begin
         if (!grant_valid) begin
            seen = 1;
            break;
         end
         @(posedge clk);
         #1;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL wait_drop: got grant still held expected release within 64 cycles");
      end
   endtask

   task automatic grant_release(input int hold, input logic [15:0] next_req);
      wait_grant();
      repeat (hold) begin
         @(posedge clk);
         #1;
      end
      rel = 1'b1;
      @(posedge clk);
      #1;
      rel = 1'b0;
      req = next_req;
   endtask

   // Monitor: pops the expected grant at each rising grant_valid, checks length and pulse at the fall.
   exp_t cur = '{idx: 4'h0, len: 0, gap: 0, to: 1'b0};
   bit   prev_v = 1'b0;
   int   hi = 0;
   int   lo = 0;

   always @(negedge clk) begin
      if (grant_valid && !prev_v) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_grant: got idx %0d expected no grant", grant_idx);
            cur = '{idx: 4'h0, len: 0, gap: 0, to: 1'b0};
         end else begin
            cur = q.pop_front();
            chk("grant_idx", grant_idx, cur.idx);
            chk("decoder_onehot", dec, 16'h1 << cur.idx);
            if (cur.gap != 0) chk("gap_cycles", lo, cur.gap);
         end
         hi = 1;
      end else if (grant_valid) begin
         hi++;
         chk("idx_stable", grant_idx, cur.idx);
      end else if (prev_v) begin
         chk("timeout_pulse", timeout_o, cur.to);
         if (cur.len != 0) chk("grant_len", hi, cur.len);
         chk("decoder_gap", dec, 16'h0);
         lo = 1;
      end else begin
         lo++;
         chk("timeout_quiet", timeout_o, 1'b0);
      end
      prev_v = grant_valid;
   end

   initial begin
      logic [3:0] seq [8] = '{4'd0, 4'd2, 4'd5, 4'd7, 4'd8, 4'd10, 4'd13, 4'd15};

      req   = 16'hFFFF;
      rel   = 1'b0;
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_valid", grant_valid, 1'b0);
      chk("reset_idx", grant_idx, 4'd0);
      chk("reset_timeout", timeout_o, 1'b0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("first_grant_valid", grant_valid, 1'b1);
      chk("first_grant_idx", grant_idx, 4'd0);

      // Full rotation 0..15,0 with single-cycle grants.
      for (int i = 0; i < 17; i++) begin
         expect_grant(4'(i % 16), 1, (i == 0) ? 0 : 1, 1'b0);
         grant_release(0, (i == 16) ? 16'h4000 : 16'hFFFF);
      end

      // Park ptr at 15 via owner 14, then wrap 15 -> 0, then lone requester 4.
      expect_grant(4'd14, 1, 1, 1'b0);
      grant_release(0, 16'h8001);
      expect_grant(4'd15, 1, 1, 1'b0);
      grant_release(0, 16'h8001);
      expect_grant(4'd0, 1, 1, 1'b0);
      grant_release(0, 16'h0010);
      for (int i = 0; i < 3; i++) begin
         expect_grant(4'd4, 1, 1, 1'b0);
         grant_release(0, (i == 2) ? 16'h0080 : 16'h0010);
      end

      // Owner 7 drops its request in grant cycle 3.
      expect_grant(4'd7, 3, 1, 1'b0);
      wait_grant();
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      req = 16'h0000;
      @(posedge clk);
      #1;
      chk("drop_valid", grant_valid, 1'b0);
      req = 16'hFFFF;
      expect_grant(4'd8, 1, 1, 1'b0);
      grant_release(0, 16'h0004);

      // Owner 2 times out after 8 cycles, then holds again with rel in cycle 8.
      expect_grant(4'd2, TO, 1, 1'b1);
      wait_grant();
      wait_drop();
      expect_grant(4'd2, TO, 1, 1'b0);
      wait_grant();
      repeat (TO - 1) begin
         @(posedge clk);
         #1;
      end
      rel = 1'b1;
      @(posedge clk);
      #1;
      rel = 1'b0;
      req = 16'hFFFF;

      // Async reset in the middle of owner 3's grant.
      expect_grant(4'd3, 0, 1, 1'b0);
      wait_grant();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_reset_valid", grant_valid, 1'b0);
      chk("async_reset_idx", grant_idx, 4'd0);
      chk("async_reset_decoder", dec, 16'h0);
      @(negedge clk);
      @(negedge clk);
      req   = 16'hA5A5;
      rst_n = 1'b1;

      // Decoder chain: after reset ptr is 0, so A5A5 is served in ascending order.
      for (int i = 0; i < 8; i++) begin
         expect_grant(seq[i], 1, (i == 0) ? 0 : 1, 1'b0);
         grant_release(0, (i == 7) ? 16'h0000 : 16'hA5A5);
      end

      repeat (5) @(negedge clk);
      chk("queue_drained", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
